nibble_entry: RTL and testbench
===============================

NIBBLE_ENTRY -- requirements
Module: nibble_entry

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 250000, the number of consecutive stable cycles required before a button level is accepted.
REQ-002 SHALL have parameter DB_W, default 18, the debounce counter width; DB_CYCLES SHALL be no greater than 2^DB_W-1.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port sw  input  4  switch-bank nibble; asynchronous to clk.
REQ-006 SHALL have port btn_load  input  1  raw load pushbutton, active-high, asynchronous.
REQ-007 SHALL have port btn_clr  input  1  raw clear pushbutton, active-high, asynchronous.
REQ-008 SHALL have ports ip1, ip2, ip3, ip4  output  4 each  captured nibbles, which drive the downstream 16-bit input register as {ip4,ip3,ip2,ip1}.
REQ-009 SHALL have port enable  output  1  0 = entry complete and downstream may capture, 1 = downstream holds its current value.
REQ-010 SHALL have port slot  output  2  index of the next nibble to be captured (0 selects ip1).
REQ-011 SHALL have port entry_done  output  1  level, high while in state DONE.

Function
REQ-012 SHALL pass sw, btn_load and btn_clr each through a two-flop synchronizer before use.
REQ-013 SHALL, per button, change the debounced level only after the synchronized input has differed from it for DB_CYCLES consecutive cycles; any bounce SHALL reset that button's counter to 0.
REQ-014 SHALL generate load_p / clr_p as single-cycle pulses on each 0->1 transition of the debounced level, with no pulse on release.
REQ-015 SHALL implement a two-state FSM: ENTER (slot 0..3) and DONE.
REQ-016 In ENTER, load_p SHALL write the synchronized sw into ip(slot+1) on the same edge and increment slot.
REQ-017 In ENTER with slot==3, load_p SHALL write ip4, set slot to 0, and go to DONE; enable SHALL fall to 0 and entry_done SHALL rise on that same edge.
REQ-018 In DONE, load_p SHALL be ignored; ip1..ip4 SHALL hold, enable SHALL stay 0, and entry_done SHALL stay 1.
REQ-019 clr_p in either state SHALL clear ip1..ip4 to 0, set slot to 0, set enable to 1, clear entry_done, and go to ENTER.
REQ-020 If load_p and clr_p occur in the same cycle, clr SHALL win and no nibble SHALL be written.
REQ-021 The outputs SHALL be registered, with no combinational path from any input to any output.
REQ-022 With DEBOUNCE_EN defined, latency from a clean btn_load rise to the ip update SHALL be 2 + DB_CYCLES + 1 cycles.

Reset
REQ-023 Asserting rst_n low SHALL, immediately and regardless of clk, set ip1..ip4=0, slot=0, enable=1, entry_done=0, state=ENTER, and clear all synchronizers, debounced levels and counters.
REQ-024 Reset mid-entry SHALL discard any partial nibble sequence.
REQ-025 Debounced levels SHALL restart at 0, so a button already held when reset deasserts SHALL produce exactly one pulse once debounced.

Configuration
REQ-026 With macro NIBBLE_ENTRY_DEBOUNCE_EN defined, debounce SHALL behave per REQ-013.
REQ-027 Without NIBBLE_ENTRY_DEBOUNCE_EN, the debounce counters SHALL be omitted and the synchronized input SHALL serve as the debounced level, giving a load latency of 2 + 1 cycles; DB_CYCLES and DB_W SHALL be unused.

Verification (DB_CYCLES=4, NIBBLE_ENTRY_DEBOUNCE_EN defined unless noted)
REQ-028 Clean presses with sw=1,2,3,4 in turn -> {ip4,ip3,ip2,ip1}=16'h4321, enable=0 and entry_done=1 after the 4th press; slot sequence 0,1,2,3,0.
REQ-029 btn_load toggling every 2 cycles for 20 cycles, then held high -> exactly one capture, with ip1 updating 7 cycles after the final rise.
REQ-030 In DONE, press load with sw=F -> no change to ip1..ip4 or enable; then press clr -> all ip=0, enable=1, slot=0.
REQ-031 load and clr debounced on the same cycle with slot=2 -> slot=0, ip all 0, ip3 not written.
REQ-032 rst_n pulsed low asynchronously mid-cycle with slot=2 -> outputs reach reset values before the next clk edge; the next 4 presses yield a full word.
REQ-033 NIBBLE_ENTRY_DEBOUNCE_EN undefined -> a single-cycle-clean btn_load rise updates ip1 3 cycles later.

Source files
------------

// File: rtl/nibble_entry.sv
// nibble_entry: four-nibble switch entry with synchronized, debounced load/clear buttons.
// Optional feature macro: NIBBLE_ENTRY_DEBOUNCE_EN (adds DB_CYCLES-cycle debounce counters).
// Without the macro, the synchronized button level is used directly as the debounced level.
module nibble_entry #(
   parameter int DB_CYCLES = 250000,
   parameter int DB_W      = 18
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw,
   input  logic       btn_load,
   input  logic       btn_clr,
   output logic [3:0] ip1,
   output logic [3:0] ip2,
   output logic [3:0] ip3,
   output logic [3:0] ip4,
   output logic       enable,
   output logic [1:0] slot,
   output logic       entry_done
);
   typedef enum logic {S_ENTER = 1'b0, S_DONE = 1'b1} state_t;

   if (DB_CYCLES < 1 || DB_CYCLES > (2 ** DB_W) - 1) begin : g_db_range
      $error("nibble_entry: DB_CYCLES does not fit in DB_W bits");
   end

   logic [3:0] r_sw_s1, r_sw_s2;
   logic [1:0] r_btn_s1, r_btn_s2;
   logic [1:0] w_deb;
   logic [1:0] r_deb_d;
   logic       w_load_p, w_clr_p;
   logic [3:0] r_ip [4];
   logic [1:0] r_slot;
   state_t     r_state, w_state_nxt;

   // Two-flop synchronizers; bit 0 is load, bit 1 is clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
         r_btn_s1 <= '0;
         r_btn_s2 <= '0;
      end else begin
         r_sw_s1  <= sw;
         r_sw_s2  <= r_sw_s1;
         r_btn_s1 <= {btn_clr, btn_load};
         r_btn_s2 <= r_btn_s1;
      end
   end

`ifdef NIBBLE_ENTRY_DEBOUNCE_EN
   logic [DB_W-1:0] r_cnt [2];
   logic [1:0]      r_deb;
   // Per button: accept a new level only after DB_CYCLES consecutive differing cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deb    <= '0;
         r_cnt[0] <= '0;
         r_cnt[1] <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (r_btn_s2[b] == r_deb[b]) begin
               r_cnt[b] <= '0;
            end else if (r_cnt[b] == DB_W'(DB_CYCLES - 1)) begin
               r_deb[b] <= r_btn_s2[b];
               r_cnt[b] <= '0;
            end else begin
               r_cnt[b] <= r_cnt[b] + 1'b1;
            end
         end
      end
   end
   assign w_deb = r_deb;
`else
   assign w_deb = r_btn_s2;
`endif

   // Delayed debounced levels for rising-edge pulse detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_deb_d <= '0;
      else        r_deb_d <= w_deb;
   end

   assign w_load_p = w_deb[0] & ~r_deb_d[0];
   assign w_clr_p  = w_deb[1] & ~r_deb_d[1];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_ENTER;
      else        r_state <= w_state_nxt;
   end

   // Next state: clear always returns to ENTER; fourth load completes the entry
   always_comb begin
      w_state_nxt = w_clr_p ? S_ENTER :
                    (w_load_p && r_state == S_ENTER && r_slot == 2'd3) ? S_DONE : r_state;
   end

   // Nibble capture and slot pointer; clear has priority over load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_ip[i] <= '0;
         r_slot <= '0;
      end else if (w_clr_p) begin
         for (int i = 0; i < 4; i++) r_ip[i] <= '0;
         r_slot <= '0;
      end else if (w_load_p && r_state == S_ENTER) begin
         r_ip[r_slot] <= r_sw_s2;
         r_slot       <= r_slot + 2'd1;
      end
   end

   // Outputs decoded straight from registers
   always_comb begin
      enable     = (r_state == S_ENTER);
      entry_done = (r_state == S_DONE);
      slot       = r_slot;
      ip1        = r_ip[0];
      ip2        = r_ip[1];
      ip3        = r_ip[2];
      ip4        = r_ip[3];
   end
endmodule

// File: tb/tb_nibble_entry.sv
// tb_nibble_entry: directed bench for nibble_entry with DB_CYCLES=4.
module tb_nibble_entry;
`ifdef NIBBLE_ENTRY_DEBOUNCE_EN
   localparam int LAT = 2 + 4 + 1;
`else
   localparam int LAT = 2 + 1;
`endif
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] sw = '0;
   logic       btn_load = 1'b0;
   logic       btn_clr = 1'b0;
   logic [3:0] ip1, ip2, ip3, ip4;
   logic       enable, entry_done;
   logic [1:0] slot;
   logic [15:0] word;
   int n_tests = 0;
   int n_fail = 0;

   assign word = {ip4, ip3, ip2, ip1};

   nibble_entry #(.DB_CYCLES(4), .DB_W(18)) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .btn_load(btn_load), .btn_clr(btn_clr),
      .ip1(ip1), .ip2(ip2), .ip3(ip3), .ip4(ip4),
      .enable(enable), .slot(slot), .entry_done(entry_done)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] v);
      sw = v;
      tick(3);
      btn_load = 1'b1;
      tick(LAT + 2);
      btn_load = 1'b0;
      tick(LAT + 2);
   endtask

   task automatic clear_press();
      btn_clr = 1'b1;
      tick(LAT + 2);
      btn_clr = 1'b0;
      tick(LAT + 2);
   endtask

   initial begin
      #3;
      chk("reset_word", word, 16'h0000);
      chk("reset_slot", 16'(slot), 16'd0);
      chk("reset_enable", 16'(enable), 16'd1);
      chk("reset_done", 16'(entry_done), 16'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // First press with exact latency check
      sw = 4'h1;
      tick(3);
      btn_load = 1'b1;
      tick(LAT - 1);
      chk("lat_before", word, 16'h0000);
      tick(1);
      chk("lat_at", word, 16'h0001);
      chk("slot_1", 16'(slot), 16'd1);
      chk("enable_mid", 16'(enable), 16'd1);
      tick(2);
      btn_load = 1'b0;
      tick(LAT + 2);

      press(4'h2);
      chk("slot_2", 16'(slot), 16'd2);
      press(4'h3);
      chk("slot_3", 16'(slot), 16'd3);
      chk("done_before_4th", 16'(entry_done), 16'd0);
      press(4'h4);
      chk("word_4321", word, 16'h4321);
      chk("enable_done", 16'(enable), 16'd0);
      chk("entry_done", 16'(entry_done), 16'd1);
      chk("slot_wrap", 16'(slot), 16'd0);

      // Load ignored in DONE, then clear
      press(4'hF);
      chk("done_hold_word", word, 16'h4321);
      chk("done_hold_enable", 16'(enable), 16'd0);
      chk("done_hold_done", 16'(entry_done), 16'd1);
      clear_press();
      chk("clr_word", word, 16'h0000);
      chk("clr_enable", 16'(enable), 16'd1);
      chk("clr_slot", 16'(slot), 16'd0);
      chk("clr_done", 16'(entry_done), 16'd0);

      // Simultaneous load and clear at slot 2: clear wins
      press(4'h1);
      press(4'h2);
      chk("pre_both_slot", 16'(slot), 16'd2);
      sw = 4'h7;
      tick(3);
      btn_load = 1'b1;
      btn_clr = 1'b1;
      tick(LAT + 2);
      chk("both_slot", 16'(slot), 16'd0);
      chk("both_word", word, 16'h0000);
      chk("both_enable", 16'(enable), 16'd1);
      btn_load = 1'b0;
      btn_clr = 1'b0;
      tick(LAT + 2);

`ifdef NIBBLE_ENTRY_DEBOUNCE_EN
      // Bouncing load: no capture until the level is stable
      sw = 4'h5;
      tick(3);
      for (int i = 0; i < 10; i++) begin
         btn_load = ~btn_load;
         tick(2);
      end
      chk("bounce_no_cap", 16'(slot), 16'd0);
      btn_load = 1'b1;
      tick(6);
      chk("bounce_before", word, 16'h0000);
      tick(1);
      chk("bounce_at", word, 16'h0005);
      tick(10);
      chk("bounce_one_cap", 16'(slot), 16'd1);
`else
      // Single clean rise captures three cycles later
      sw = 4'h5;
      tick(3);
      btn_load = 1'b1;
      tick(2);
      chk("nodb_before", word, 16'h0000);
      tick(1);
      chk("nodb_at", word, 16'h0005);
      tick(5);
      chk("nodb_one_cap", 16'(slot), 16'd1);
`endif
      btn_load = 1'b0;
      tick(LAT + 2);

      // Asynchronous reset mid-entry
      press(4'h6);
      chk("pre_rst_slot", 16'(slot), 16'd2);
      #3;
      rst_n = 1'b0;
      #2;
      chk("arst_word", word, 16'h0000);
      chk("arst_slot", 16'(slot), 16'd0);
      chk("arst_enable", 16'(enable), 16'd1);
      #1;
      rst_n = 1'b1;
      tick(2);
      press(4'h8);
      press(4'h9);
      press(4'hA);
      press(4'hB);
      chk("post_rst_word", word, 16'hBA98);
      chk("post_rst_done", 16'(entry_done), 16'd1);
      chk("post_rst_enable", 16'(enable), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
